// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: forward selects and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EXE  = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_LOAD = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand ID-stage forward selector; EX result beats MEM result, r0 never forwards.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] ern,
  input  logic       ewreg,
  input  logic [4:0] mrn,
  input  logic       mwreg,
  input  logic       mm2reg,
  output logic [1:0] sel
);

  // Pick the youngest in-flight producer of the source register.
  always_comb begin
    sel = FWD_REG;
    if (use_src && (src != 5'd0)) begin
      if (ewreg && (ern == src))
        sel = FWD_EXE;
      else if (mwreg && (mrn == src))
        sel = mm2reg ? FWD_LOAD : FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: forwarding, load-use stall, branch squash, data-memory freeze.
// Latency: controls are combinational from current inputs and FSM state; mem_err is registered.
// Backpressure: a data-memory stall freezes every stage; PIPE_PERF_CNT_EN adds event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
`ifdef PIPE_PERF_CNT_EN
  ,parameter int CNT_W = 16
`endif
)(
  input  logic       clk,
  input  logic       clrn,
  input  logic [4:0] drs,
  input  logic [4:0] drt,
  input  logic       duse_rs,
  input  logic       duse_rt,
  input  logic [4:0] ern,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] mrn,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic       eBTAKEN,
  input  logic       mreq,
  input  logic       mready,
  output logic [1:0] dADEPEEN,
  output logic [1:0] dBDEPEEN,
  output logic       wpcir,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       freeze,
  output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
  ,output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mwait_cnt
`endif
);

  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           timeout;
  logic           load_use;
  logic           mem_stall;
  logic           br_flush;
  logic           lu_stall;

  pipe_fwd_sel u_fwd_a (
    .src(drs), .use_src(duse_rs), .ern(ern), .ewreg(ewreg),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .sel(dADEPEEN)
  );

  pipe_fwd_sel u_fwd_b (
    .src(drt), .use_src(duse_rt), .ern(ern), .ewreg(ewreg),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .sel(dBDEPEEN)
  );

  // Hazard classification and priority: memory stall > branch flush > load-use.
  // While clrn is low every control is forced inactive so the pipe is released at once.
  always_comb begin
    timeout   = (state == ST_MWAIT) && (wait_cnt == WAIT_LAST);
    load_use  = ewreg && em2reg && (ern != 5'd0) &&
                ((duse_rs && (ern == drs)) || (duse_rt && (ern == drt)));
    mem_stall = clrn && (((state == ST_RUN) && mreq && !mready) ||
                         ((state == ST_MWAIT) && !mready && !timeout));
    br_flush  = clrn && !mem_stall && eBTAKEN;
    lu_stall  = clrn && !mem_stall && !eBTAKEN && load_use;

    freeze      = mem_stall;
    wpcir       = !(mem_stall || lu_stall);
    ifid_flush  = br_flush;
    idex_bubble = br_flush || lu_stall;
  end

  // Memory-wait FSM with bounded wait; a timeout exit raises the sticky error flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (mreq && !mready) state <= ST_MWAIT;
        end
        ST_MWAIT: begin
          if (mready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (timeout) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating event counters for stall, flush and memory-wait cycles.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      mwait_cnt <= '0;
    end else begin
      if (lu_stall  && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (br_flush  && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (mem_stall && (mwait_cnt != '1)) mwait_cnt <= mwait_cnt + 1'b1;
    end
  end
`endif

endmodule
